// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCK/CS_n/COPI in clk_i, deserialises RX bytes and serialises TX bytes on CIPO.
// Optional build macro SPI_TARGET_BYTE_CNT_EN adds the 16-bit saturating per-frame byte counter on byte_cnt_o.
module spi_target #(
  parameter int unsigned SyncStages = 2,
  parameter bit          MsbFirst   = 1'b1,
  parameter logic [7:0]  TxIdleByte = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sck_i,
  input  logic        cs_ni,
  input  logic        copi_i,
  output logic        cipo_o,
  output logic        cipo_oe_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        rx_overrun_o,
  output logic        tx_underrun_o,
  output logic [15:0] byte_cnt_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SyncStages-1:0] sck_sync, cs_sync, copi_sync;
  logic s_sck_q, s_cs_q;
  logic s_sck, s_cs_n, s_copi;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh, tx_sh, tx_next, rx_next;
  logic       byte_done;
  logic       frame_start, byte_end, load_evt;

  // CS_n synchronisers reset to "selected" so a host already holding CS low
  // across reset does not look like a fresh falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      s_sck_q   <= 1'b0;
      s_cs_q    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SyncStages-2:0], sck_i};
      cs_sync   <= {cs_sync[SyncStages-2:0], cs_ni};
      copi_sync <= {copi_sync[SyncStages-2:0], copi_i};
      s_sck_q   <= s_sck;
      s_cs_q    <= s_cs_n;
    end
  end

  assign s_sck    = sck_sync[SyncStages-1];
  assign s_cs_n   = cs_sync[SyncStages-1];
  assign s_copi   = copi_sync[SyncStages-1];
  assign sck_rise =  s_sck & ~s_sck_q;
  assign sck_fall = ~s_sck &  s_sck_q;
  assign cs_fall  = ~s_cs_n &  s_cs_q;
  assign cs_rise  =  s_cs_n & ~s_cs_q;

  function automatic logic first_bit(input logic [7:0] b);
    return MsbFirst ? b[7] : b[0];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return MsbFirst ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
  endfunction

  assign tx_next     = tx_valid_i ? tx_data_i : TxIdleByte;
  assign rx_next     = MsbFirst ? {rx_sh[6:0], s_copi} : {s_copi, rx_sh[7:1]};
  assign frame_start = (state == IDLE) & cs_fall;
  assign byte_end    = (state == ACTIVE) & ~cs_rise & sck_rise & (bit_cnt == 3'd7);
  assign load_evt    = ~rst_i & (frame_start | byte_end);

  // The TX handshake is same-cycle: the byte on tx_data_i is taken at the clock edge ending this pulse.
  assign tx_ready_o    = load_evt & tx_valid_i;
  assign tx_underrun_o = load_evt & ~tx_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      rx_sh        <= 8'h00;
      tx_sh        <= 8'h00;
      byte_done    <= 1'b0;
      cipo_o       <= 1'b1;
      cipo_oe_o    <= 1'b0;
      rx_data_o    <= 8'h00;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      byte_done    <= 1'b0;
      rx_overrun_o <= 1'b0;

      // A completed byte lands one cycle after the last SCK rise; an accept in that cycle frees the slot.
      if (rx_valid_o && rx_ready_i)
        rx_valid_o <= 1'b0;
      if (byte_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= rx_sh;
          rx_valid_o <= 1'b1;
        end else begin
          rx_overrun_o <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cipo_oe_o <= 1'b0;
          if (cs_fall) begin
            state     <= ACTIVE;
            cipo_oe_o <= 1'b1;
            bit_cnt   <= 3'd0;
            cipo_o    <= first_bit(tx_next);
            tx_sh     <= shift_out(tx_next);
          end
        end
        ACTIVE: begin
          cipo_oe_o <= 1'b1;
          if (cs_rise) begin
            state     <= IDLE;
            cipo_oe_o <= 1'b0;
            bit_cnt   <= 3'd0;
            cipo_o    <= 1'b1;
          end else begin
            if (sck_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                tx_sh     <= tx_next;
              end
            end
            // tx_sh always holds the bits still to be driven, so a reload and a mid-byte fall look the same.
            if (sck_fall) begin
              cipo_o <= first_bit(tx_sh);
              tx_sh  <= shift_out(tx_sh);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_TARGET_BYTE_CNT_EN
  logic [15:0] byte_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      byte_cnt <= 16'h0000;
    else if (frame_start)
      byte_cnt <= 16'h0000;
    else if (byte_end && byte_cnt != 16'hFFFF)
      byte_cnt <= byte_cnt + 16'h0001;
  end

  assign byte_cnt_o = byte_cnt;
`else
  assign byte_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an MSB-first and an LSB-first instance share one emulated SPI host.
`timescale 1ns/1ps
module tb_spi_target;
  localparam int unsigned SYNC = 2;
`ifdef SPI_TARGET_BYTE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0, cs_n = 1'b1, copi = 1'b0;
  always #5 clk = ~clk;

  // MSB-first instance
  logic        cipo, cipo_oe, rx_valid, rx_ready, tx_valid, tx_ready, rx_ovr, tx_und;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] byte_cnt;
  // LSB-first instance
  logic        cipo_l, cipo_oe_l, rx_valid_l, tx_valid_l, tx_ready_l, rx_ovr_l, tx_und_l;
  logic [7:0]  rx_data_l, tx_data_l;
  logic [15:0] byte_cnt_l;
  logic        rx_ready_l = 1'b1;

  spi_target #(.SyncStages(SYNC), .MsbFirst(1'b1), .TxIdleByte(8'hFF)) u_dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_ni(cs_n), .copi_i(copi),
    .cipo_o(cipo), .cipo_oe_o(cipo_oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_overrun_o(rx_ovr), .tx_underrun_o(tx_und), .byte_cnt_o(byte_cnt));

  spi_target #(.SyncStages(SYNC), .MsbFirst(1'b0), .TxIdleByte(8'hFF)) u_dut_lsb (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_ni(cs_n), .copi_i(copi),
    .cipo_o(cipo_l), .cipo_oe_o(cipo_oe_l), .rx_data_o(rx_data_l), .rx_valid_o(rx_valid_l),
    .rx_ready_i(rx_ready_l), .tx_data_i(tx_data_l), .tx_valid_i(tx_valid_l), .tx_ready_o(tx_ready_l),
    .rx_overrun_o(rx_ovr_l), .tx_underrun_o(tx_und_l), .byte_cnt_o(byte_cnt_l));

  // TX producers offer exactly tx_budget bytes, then go idle.
  int tx_budget = 0, tx_budget_l = 0;
  int n_txr = 0, n_txu = 0, n_ovr = 0, n_rxv = 0, n_txr_l = 0;
  logic [7:0] rx_last = 8'h00, rx_last_l = 8'h00;
  logic rv_q = 1'b0, rv_q_l = 1'b0;
  time t_valid = 0, t_valid_l = 0, t_rise = 0;

  assign tx_valid   = (n_txr < tx_budget);
  assign tx_valid_l = (n_txr_l < tx_budget_l);

  always @(posedge clk) begin
    n_txr   <= n_txr + int'(tx_ready);
    n_txu   <= n_txu + int'(tx_und);
    n_ovr   <= n_ovr + int'(rx_ovr);
    n_rxv   <= n_rxv + int'(rx_valid);
    n_txr_l <= n_txr_l + int'(tx_ready_l);
    rv_q    <= rx_valid;
    rv_q_l  <= rx_valid_l;
    if (rx_valid && !rv_q) t_valid <= $time;
    if (rx_valid_l && !rv_q_l) t_valid_l <= $time;
    if (rx_valid && rx_ready) rx_last <= rx_data;
    if (rx_valid_l && rx_ready_l) rx_last_l <= rx_data_l;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Host drives pins 3ns before a posedge; SCK = clk/8.
  task automatic xfer(input logic [7:0] d, input bit lsb, input int nbits,
                      output logic [7:0] m, output logic [7:0] ml);
    m  = 8'h00;
    ml = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx  = lsb ? i : 7 - i;
      copi = d[idx];
      #40;
      sck       = 1'b1;
      m[idx]    = cipo;
      ml[idx]   = cipo_l;
      t_rise    = $time;
      #40;
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    #80;
    cs_n = 1'b1;
    #80;
  endtask

  // rx_valid becomes visible SYNC+2 edges after the pin edge; the bench sees it one edge later.
  localparam int LAT = 10 * (SYNC + 2) + 3;

  initial begin
    logic [7:0] m, ml, m1, m2;
    int s0, s1, s2;
    rx_ready  = 1'b1;
    tx_data   = 8'h3C;
    tx_data_l = 8'h0D;
    #2;
    #100;
    rst = 1'b0;
    #20;

    check("rst_cipo",     32'(cipo), 32'h1);
    check("rst_oe",       32'(cipo_oe), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_data",  32'(rx_data), 32'h0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'h0);
    check("rst_pulses",   32'({tx_ready, tx_und, rx_ovr}), 32'h0);

    // Single byte A5 out, 3C back
    tx_budget = tx_budget + 1;
    s0 = n_txr; s1 = n_rxv;
    frame_start();
    check("oe_active", 32'(cipo_oe), 32'h1);
    xfer(8'hA5, 1'b0, 8, m, ml);
    frame_end();
    check("oe_idle",       32'(cipo_oe), 32'h0);
    check("a5_rx",         32'(rx_last), 32'hA5);
    check("a5_miso",       32'(m), 32'h3C);
    check("a5_valid_cyc",  32'(n_rxv - s1), 32'd1);
    check("a5_tx_ready",   32'(n_txr - s0), 32'd1);
    check("a5_latency",    32'(t_valid - t_rise), 32'(LAT));

    // Three bytes, consumer stalled
    rx_ready = 1'b0;
    s0 = n_ovr;
    frame_start();
    xfer(8'h01, 1'b0, 8, m, ml);
    xfer(8'h02, 1'b0, 8, m, ml);
    xfer(8'h03, 1'b0, 8, m, ml);
    frame_end();
    check("ovr_valid",    32'(rx_valid), 32'h1);
    check("ovr_data",     32'(rx_data), 32'h01);
    check("ovr_pulses",   32'(n_ovr - s0), 32'd2);
    check("ovr_byte_cnt", 32'(byte_cnt), CNT_EN ? 32'd3 : 32'd0);
    rx_ready = 1'b1;
    #20;
    check("accept_drop", 32'(rx_valid), 32'h0);

    // No TX data: idle bytes and underruns
    s0 = n_txu;
    frame_start();
    xfer(8'h11, 1'b0, 8, m1, ml);
    s2 = n_txu;
    xfer(8'h22, 1'b0, 8, m2, ml);
    frame_end();
    check("und_miso0",  32'(m1), 32'hFF);
    check("und_miso1",  32'(m2), 32'hFF);
    check("und_pulses", 32'(s2 - s0), 32'd2);
    check("und_rx",     32'(rx_last), 32'h22);

    // Aborted partial byte, then a clean frame
    s1 = n_rxv; s0 = n_ovr;
    frame_start();
    xfer(8'hFF, 1'b0, 5, m, ml);
    frame_end();
    check("abort_valid", 32'(n_rxv - s1), 32'd0);
    check("abort_ovr",   32'(n_ovr - s0), 32'd0);
    frame_start();
    xfer(8'h5A, 1'b0, 8, m, ml);
    frame_end();
    check("abort_next_rx",  32'(rx_last), 32'h5A);
    check("abort_byte_cnt", 32'(byte_cnt), CNT_EN ? 32'd1 : 32'd0);

    // Reset mid-byte with a byte still unread
    rx_ready = 1'b0;
    frame_start();
    xfer(8'h77, 1'b0, 8, m, ml);
    xfer(8'hC0, 1'b0, 4, m, ml);
    check("pre_rst_valid", 32'(rx_valid), 32'h1);
    rst = 1'b1;
    #10;
    rst = 1'b0;
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_data",  32'(rx_data), 32'h0);
    check("mid_rst_oe",    32'(cipo_oe), 32'h0);
    check("mid_rst_cipo",  32'(cipo), 32'h1);
    check("mid_rst_cnt",   32'(byte_cnt), 32'h0);
    xfer(8'h00, 1'b0, 4, m, ml);
    #80;
    check("post_rst_oe", 32'(cipo_oe), 32'h0);
    cs_n = 1'b1;
    #80;
    rx_ready = 1'b1;
    frame_start();
    xfer(8'hC3, 1'b0, 8, m, ml);
    frame_end();
    check("post_rst_rx", 32'(rx_last), 32'hC3);

    // LSB-first instance
    tx_budget_l = tx_budget_l + 1;
    s0 = n_txr_l;
    frame_start();
    check("lsb_oe", 32'(cipo_oe_l), 32'h1);
    xfer(8'h01, 1'b1, 8, m, ml);
    frame_end();
    check("lsb_rx",       32'(rx_last_l), 32'h01);
    check("lsb_miso",     32'(ml), 32'h0D);
    check("lsb_tx_ready", 32'(n_txr_l - s0), 32'd1);
    check("lsb_latency",  32'(t_valid_l - t_rise), 32'(LAT));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
